// File: rtl/hub75_capture.sv
`default_nettype none
// ============================================================================
// Module   : hub75_capture
// Brief    : HUB75 receive-side model. Oversamples the panel bus, rebuilds the
//            shift chain and commits latched rows into a 16x32x3 frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_capture #(
    parameter int COLS      = 32,
    parameter int ROWS_HALF = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] rgb,
    input  logic       outclk,
    input  logic       lat,
    input  logic       oe,
    input  logic [2:0] abc,
    input  logic [3:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [2:0] rd_rgb,
    output logic       row_commit,
    output logic [2:0] commit_row,
    output logic       frame_done,
    output logic       err_short,
    output logic       err_lat_lit,
    input  logic       err_clr
);

    localparam logic [5:0] c_cols     = 6'(COLS);
    localparam logic [2:0] c_last_row = 3'(ROWS_HALF - 1);
    localparam int         c_rows     = 2 * ROWS_HALF;

    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Bus bit map: rgb[5:0], outclk[6], lat[7], oe[8], abc[11:9]
    logic [11:0] w_async;
    logic [11:0] r_sync1;
    logic [11:0] r_sync2;
    logic [1:0]  r_edge3;

    logic [5:0]  w_rgb_s;
    logic        w_oe_s;
    logic [2:0]  w_abc_s;
    logic        w_shift;
    logic        w_lat_rise;

    logic [5:0]  r_chain      [COLS];
    logic [5:0]  w_chain_next [COLS];
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_next;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_commit;
    logic        w_set_short;
    logic        w_set_lit;

    logic [2:0]  r_fb [c_rows][COLS];
    logic [3:0]  w_top_row;
    logic [3:0]  w_bot_row;

    assign w_async = {abc, oe, lat, outclk, rgb};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_edge3 <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
            r_edge3 <= r_sync2[7:6];
        end
    end

    assign w_rgb_s    = r_sync2[5:0];
    assign w_oe_s     = r_sync2[8];
    assign w_abc_s    = r_sync2[11:9];
    assign w_shift    = r_sync2[6] & ~r_edge3[0];
    assign w_lat_rise = r_sync2[7] & ~r_edge3[1];
    assign w_top_row  = {1'b0, w_abc_s};
    assign w_bot_row  = {1'b1, w_abc_s};

    // Post-shift view of the chain, so a coincident latch commits the new pixel
    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            w_chain_next[i] = r_chain[i];
        end
        if (w_shift) begin
            w_chain_next[0] = w_rgb_s;
            for (int i = 1; i < COLS; i++) begin
                w_chain_next[i] = r_chain[i-1];
            end
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_shift && (r_cnt != c_cols)) begin
            w_cnt_next = r_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COLS; i++) begin
                r_chain[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < COLS; i++) begin
                r_chain[i] <= w_chain_next[i];
            end
            r_cnt <= w_lat_rise ? 6'd0 : w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ALIGN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_set_short  = 1'b0;
        w_set_lit    = 1'b0;
        case (r_state)
            ST_ALIGN: begin
                if (w_lat_rise) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_lat_rise) begin
                    if (w_cnt_next == c_cols) begin
                        w_commit = 1'b1;
                    end else begin
                        w_set_short = 1'b1;
                    end
                    w_set_lit = ~w_oe_s;
                end
            end
            default: begin
                w_state_next = ST_ALIGN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < c_rows; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_fb[r][c] <= '0;
                end
            end
        end else if (w_commit) begin
            for (int c = 0; c < COLS; c++) begin
                r_fb[w_top_row][c] <= w_chain_next[c][5:3];
                r_fb[w_bot_row][c] <= w_chain_next[c][2:0];
            end
        end
    end

    // Registered read sees pre-commit contents when it collides with a write
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rgb <= '0;
        end else begin
            rd_rgb <= r_fb[rd_row][rd_col];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_commit  <= 1'b0;
            frame_done  <= 1'b0;
            commit_row  <= '0;
            err_short   <= 1'b0;
            err_lat_lit <= 1'b0;
        end else begin
            row_commit <= w_commit;
            frame_done <= w_commit && (w_abc_s == c_last_row);
            if (w_commit) begin
                commit_row <= w_abc_s;
            end
            if (err_clr) begin
                err_short   <= 1'b0;
                err_lat_lit <= 1'b0;
            end else begin
                if (w_set_short) begin
                    err_short <= 1'b1;
                end
                if (w_set_lit) begin
                    err_lat_lit <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_capture
// Brief    : Self-checking bench for hub75_capture: commit scoreboard plus
//            table-driven frame buffer readback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] rgb = '0;
    logic       outclk = 1'b0;
    logic       lat = 1'b0;
    logic       oe = 1'b1;
    logic [2:0] abc = '0;
    logic [3:0] rd_row = '0;
    logic [4:0] rd_col = '0;
    logic [2:0] rd_rgb;
    logic       row_commit;
    logic [2:0] commit_row;
    logic       frame_done;
    logic       err_short;
    logic       err_lat_lit;
    logic       err_clr = 1'b0;

    hub75_capture #(.COLS(32), .ROWS_HALF(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rgb        (rgb),
        .outclk     (outclk),
        .lat        (lat),
        .oe         (oe),
        .abc        (abc),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_rgb     (rd_rgb),
        .row_commit (row_commit),
        .commit_row (commit_row),
        .frame_done (frame_done),
        .err_short  (err_short),
        .err_lat_lit(err_lat_lit),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] row;
        logic       fd;
    } commit_t;

    typedef struct {
        logic [3:0] row;
        logic [4:0] col;
        logic [2:0] exp;
    } rd_vec_t;

    commit_t sb[$];
    rd_vec_t tbl[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      n_fd     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Commit monitor: every row_commit must match the oldest expected commit
    always @(negedge clk) begin
        if (!reset && row_commit) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", 1, 0);
            end else begin
                commit_t e;
                e = sb.pop_front();
                chk("commit_row", int'(commit_row), int'(e.row));
                chk("frame_done", int'(frame_done), int'(e.fd));
            end
        end
        if (!reset && frame_done) begin
            n_fd++;
            if (!row_commit) chk("frame_done_alone", 1, 0);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_px(input logic [5:0] p);
        @(negedge clk);
        rgb = p;
        wait_clks(2);
        outclk = 1'b1;
        wait_clks(3);
        outclk = 1'b0;
        wait_clks(2);
    endtask

    task automatic pulse_lat(input logic [2:0] a, input logic o, input logic expect_commit);
        @(negedge clk);
        abc = a;
        oe  = o;
        if (expect_commit) begin
            commit_t e;
            e.row = a;
            e.fd  = (a == 3'd7);
            sb.push_back(e);
        end
        wait_clks(3);
        lat = 1'b1;
        wait_clks(3);
        lat = 1'b0;
        oe  = 1'b1;
        wait_clks(4);
    endtask

    // Bounded wait for every expected commit to have been observed
    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic rd_chk(input logic [3:0] r, input logic [4:0] c, input logic [2:0] e,
                          input string name);
        @(negedge clk);
        rd_row = r;
        rd_col = c;
        @(posedge clk);
        #1;
        chk(name, int'(rd_rgb), int'(e));
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            rd_chk(tbl[i].row, tbl[i].col, tbl[i].exp, name);
        end
        tbl.delete();
    endtask

    task automatic add_vec(input int r, input int c, input int e);
        rd_vec_t v;
        v.row = 4'(r);
        v.col = 5'(c);
        v.exp = 3'(e);
        tbl.push_back(v);
    endtask

    initial begin
        logic [4:0] k5;
        logic [4:0] k6;
        logic [5:0] px;

        wait_clks(4);
        reset = 1'b0;
        wait_clks(1);
        chk("reset_rd_rgb", int'(rd_rgb), 0);
        chk("reset_row_commit", int'(row_commit), 0);
        chk("reset_commit_row", int'(commit_row), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_err_short", int'(err_short), 0);
        chk("reset_err_lat_lit", int'(err_lat_lit), 0);

        // Row 1: ALIGN latch, 32 shifts of k[2:0] on both halves, commit abc=3
        pulse_lat(3'd3, 1'b1, 1'b0);
        drain("align_no_commit");
        for (int k = 0; k < 32; k++) begin
            k5 = 5'(k);
            shift_px({k5[2:0], k5[2:0]});
        end
        pulse_lat(3'd3, 1'b1, 1'b1);
        drain("row1_commit");
        chk("row1_err_short", int'(err_short), 0);
        chk("row1_err_lat_lit", int'(err_lat_lit), 0);
        for (int c = 0; c < 32; c++) begin
            add_vec(3, c, (31 - c) % 8);
            add_vec(11, c, (31 - c) % 8);
        end
        run_table("row1_read");

        // 37 shifts: 32 data then 5 zeros, abc=5
        for (int k = 0; k < 37; k++) begin
            k5 = 5'(k);
            px = (k < 32) ? {k5[2:0], ~k5[2:0]} : 6'd0;
            shift_px(px);
        end
        pulse_lat(3'd5, 1'b1, 1'b1);
        drain("over_commit");
        for (int c = 0; c < 32; c++) begin
            add_vec(5, c, (c < 5) ? 0 : (36 - c) % 8);
            add_vec(13, c, (c < 5) ? 0 : 7 - ((36 - c) % 8));
        end
        run_table("over_read");

        // Short row: 20 shifts into abc=3, buffer must be untouched
        for (int k = 0; k < 20; k++) shift_px(6'b111111);
        pulse_lat(3'd3, 1'b1, 1'b0);
        drain("short_no_commit");
        chk("short_err_short", int'(err_short), 1);
        chk("short_err_lat_lit", int'(err_lat_lit), 0);
        add_vec(3, 0, 7);
        add_vec(3, 31, 0);
        add_vec(11, 10, 5);
        run_table("short_buffer_kept");
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        wait_clks(1);
        chk("err_clr_short", int'(err_short), 0);
        for (int k = 0; k < 32; k++) shift_px(6'b001001);
        pulse_lat(3'd6, 1'b1, 1'b1);
        drain("good_after_clr");
        chk("good_after_clr_err", int'(err_short), 0);

        // Latch while lit: commits and flags err_lat_lit
        for (int k = 0; k < 32; k++) shift_px(6'b110011);
        pulse_lat(3'd2, 1'b0, 1'b1);
        drain("lit_commit");
        chk("lit_err_lat_lit", int'(err_lat_lit), 1);
        chk("lit_err_short", int'(err_short), 0);
        add_vec(2, 17, 6);
        add_vec(10, 17, 3);
        run_table("lit_read");

        // Full frame with border columns 010, interior 101
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 32; k++) begin
                px = (k == 0 || k == 31) ? 6'b010010 : 6'b101101;
                shift_px(px);
            end
            pulse_lat(3'(r), 1'b1, 1'b1);
        end
        drain("frame_commits");
        chk("frame_done_count", n_fd, 1);
        for (int r = 0; r < 16; r++) begin
            add_vec(r, 0, 2);
            add_vec(r, 31, 2);
        end
        add_vec(7, 15, 5);
        add_vec(8, 1, 5);
        run_table("frame_border");

        // Reset mid-row after 15 shifts
        for (int k = 0; k < 15; k++) shift_px(6'b111111);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_rd_rgb", int'(rd_rgb), 0);
        chk("mid_reset_row_commit", int'(row_commit), 0);
        chk("mid_reset_commit_row", int'(commit_row), 0);
        chk("mid_reset_frame_done", int'(frame_done), 0);
        chk("mid_reset_err_short", int'(err_short), 0);
        chk("mid_reset_err_lat_lit", int'(err_lat_lit), 0);
        add_vec(3, 0, 0);
        add_vec(7, 0, 0);
        add_vec(15, 31, 0);
        add_vec(12, 20, 0);
        run_table("mid_reset_buffer");
        pulse_lat(3'd4, 1'b1, 1'b0);
        drain("realign_no_commit");
        chk("realign_err_short", int'(err_short), 0);
        for (int k = 0; k < 32; k++) begin
            k5 = 5'(k);
            k6 = k5 + 5'd1;
            shift_px({k5[2:0], k6[2:0]});
        end
        pulse_lat(3'd4, 1'b1, 1'b1);
        drain("realign_commit");
        chk("realign_err_after", int'(err_short), 0);
        for (int c = 0; c < 32; c += 5) begin
            add_vec(4, c, (31 - c) % 8);
            add_vec(12, c, (32 - c) % 8);
        end
        run_table("realign_read");
        chk("frame_done_total", n_fd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hub75_capture.md
# hub75_capture

Receive-side model of the HUB75 panel interface driven by the display drivers. It oversamples `rgb`, `outclk`, `lat`, `oe` and `abc` on a fast system clock and rebuilds the 32-column shift chain. Each latched row is committed into a 16x32x3 frame buffer that a host or testbench can read back. It also flags protocol violations, so it serves both as a loopback checker on the FPGA and as the panel model in simulation.

## Interface
- COLS, 32: shift-chain length in pixels.
- ROWS_HALF, 8: rows per half-panel, addressed by `abc`.
- clk  in  1  system clock; at least 4x the `outclk` rate.
- reset  in  1  synchronous, active-high; clears all state.
- rgb  in  6  {R1,G1,B1,R2,G2,B2} from the driver; asynchronous to `clk`.
- outclk  in  1  panel shift clock; asynchronous.
- lat  in  1  row latch; asynchronous.
- oe  in  1  output enable, active-low (1 = blanked); asynchronous.
- abc  in  3  row select; asynchronous.
- rd_row  in  4  read row; 0-7 are the top half, 8-15 the bottom half.
- rd_col  in  5  read column 0-31.
- rd_rgb  out  3  {R,G,B} at (`rd_row`, `rd_col`); registered.
- row_commit  out  1  one-cycle pulse when a row is written.
- commit_row  out  3  `abc` value of the last commit; holds until the next commit.
- frame_done  out  1  one-cycle pulse on the commit of `abc` = 7.
- err_short  out  1  sticky: `lat` rose with fewer than COLS shifts since the previous `lat`.
- err_lat_lit  out  1  sticky: `lat` rose while `oe` = 0.
- err_clr  in  1  clears both sticky errors.

## Operation
- Every panel input passes through a 2-FF synchronizer followed by a third delay stage. An edge is a rise when sync stage 2 is 1 and stage 3 is 0.
- Shift chain: COLS x 6-bit register.
  - On an `outclk` rise, the chain shifts by one and stage-2 `rgb` enters at position 0.
  - The first pixel shifted after a latch ends up in column COLS-1, the last in column 0.
  - Extra shifts push the oldest data out. Only the last COLS pixels before `lat` matter.
- shift_cnt: 6 bits, saturates at COLS, cleared on every `lat` rise.
- FSM states:
  - ALIGN (reset state): shifts are counted, no commits occur, no errors are raised. A `lat` rise moves to RUN and clears shift_cnt.
  - RUN, on a `lat` rise:
    - If shift_cnt = COLS: commit the row. Top-half pixels (bits 5:3) go to frame row `abc`; bottom-half pixels (bits 2:0) go to frame row `abc`+8.
    - If shift_cnt < COLS: set `err_short`; the frame buffer is unchanged.
    - In either case, if stage-2 `oe` = 0, set `err_lat_lit`.
- `abc` and `oe` are sampled at the same sync stage as the `lat` rise.
- Simultaneous `outclk` rise and `lat` rise in one cycle: the shift is applied first, the count includes it, and the commit uses the post-shift chain.
- `err_clr` has priority over error setting in the same cycle.
- Frame buffer: 16 rows x 32 columns x 3 bits, held in flops. A whole row is written per commit. Reset clears it to 0.
- Read: `rd_rgb` is registered from the buffer at (`rd_row`, `rd_col`). A read in the same cycle as a write to the same row returns the old data.

## Timing
- Reset values: `rd_rgb`=0, `row_commit`=0, `commit_row`=0, `frame_done`=0, `err_short`=0, `err_lat_lit`=0. FSM = ALIGN, shift_cnt=0, chain=0.
- Input-to-edge-detect latency: 2-3 `clk` cycles.
- `outclk` high and low phases must each last at least 2 `clk` periods. `rgb` must be stable for 3 `clk` periods around the `outclk` rise.
- Commit timing:
  - `lat` rise detected in cycle N; the buffer and `commit_row` update at the end of N.
  - `row_commit` (and `frame_done` if applicable) is high during N+1.
  - A read issued in N+1 returns the new data in N+2.
- Read latency: 1 cycle.
- Sticky errors assert in N+1 and hold until `err_clr` or `reset`.
- `reset` mid-row: everything clears the next cycle, including the buffer. Capture re-aligns on the next `lat`.

## Test plan
- Reset then one driver row: `lat`, then 32 `outclk` pulses with pixel k = k[2:0] replicated on both halves, `abc`=3, `lat` with `oe`=1.
  - Expect no commit on the first `lat` (ALIGN).
  - Expect `row_commit`, `commit_row`=3.
  - Expect rows 3 and 11 read back column c = (31-c)[2:0].
  - Expect both errors = 0.
- 37 shifts before `lat` (driver pattern: 32 data then 5 zeros): columns 5-31 hold data pixels 5-31, columns 0-4 read 0.
- Only 20 shifts, then `lat`:
  - `err_short`=1, no `row_commit`, buffer unchanged.
  - `err_clr` drops it, and it stays 0 on the next good row.
- `lat` while `oe`=0 with 32 shifts: row commits and `err_lat_lit`=1.
- Full frame `abc`=0..7 with the border pattern:
  - Expect exactly one `frame_done`, on `abc`=7.
  - Expect column 0 and column 31 to read 3'b010 in all 16 rows.
- Synchronous `reset` asserted after 15 shifts:
  - All outputs and the buffer read 0.
  - The following `lat` realigns without error, and the next 32-shift row commits.
